// File: rtl/mem_bank_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous memory
// bank. It grants one request per cycle, issues registered bank commands,
// and steers the returned read data back to the port that asked for it.
module mem_bank_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e             ptr_q;
  logic              tag_vld_q;
  port_e             tag_port_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Grant selection: a lone requester always wins; contention is settled by
  // the round-robin pointer or by fixed priority to A. Nothing granted in reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        if (ARB_MODE == 1 || ptr_q == PORT_A) a_gnt = 1'b1;
        else                                  b_gnt = 1'b1;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Round-robin pointer: advances only when the pointed-to port is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PORT_A;
    end else if (a_gnt && ptr_q == PORT_A) begin
      ptr_q <= PORT_B;
    end else if (b_gnt && ptr_q == PORT_B) begin
      ptr_q <= PORT_A;
    end
  end

  // Command issue: register the granted port's fields and tag reads with
  // their originating port; address and write data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      tag_vld_q      <= 1'b0;
      tag_port_q     <= PORT_A;
    end else if (a_gnt) begin
      mem_address    <= a_addr;
      mem_write_data <= a_wdata;
      mem_write      <= a_we;
      mem_read       <= ~a_we;
      tag_vld_q      <= ~a_we;
      tag_port_q     <= PORT_A;
    end else if (b_gnt) begin
      mem_address    <= b_addr;
      mem_write_data <= b_wdata;
      mem_write      <= b_we;
      mem_read       <= ~b_we;
      tag_vld_q      <= ~b_we;
      tag_port_q     <= PORT_B;
    end else begin
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      tag_vld_q      <= 1'b0;
    end
  end

  // Read return: the valid strobe follows the tag by one cycle, and the data
  // seen during that strobe is latched so rdata keeps it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rvalid <= tag_vld_q && (tag_port_q == PORT_A);
      b_rvalid <= tag_vld_q && (tag_port_q == PORT_B);
      if (a_rvalid) a_rdata_q <= mem_read_data;
      if (b_rvalid) b_rdata_q <= mem_read_data;
    end
  end

  // The bank's read register is already the second pipeline stage, so during
  // the strobe cycle rdata passes it straight through; otherwise the latch.
  always_comb begin
    a_rdata = a_rvalid ? mem_read_data : a_rdata_q;
    b_rdata = b_rvalid ? mem_read_data : b_rdata_q;
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter: a round-robin instance and a
// fixed-priority instance share the requester stimulus, each with its own
// behavioural memory bank.
module tb_mem_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;

  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mw, mr;
  logic [7:0] a_rdata, b_rdata, maddr, mwd, mrd;
  logic       fa_gnt, fa_rvalid, fb_gnt, fb_rvalid, fmw, fmr;
  logic [7:0] fa_rdata, fb_rdata, fmaddr, fmwd, fmrd;

  logic [7:0] bank0 [256];
  logic [7:0] bank1 [256];
  bit         init0, init1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(maddr), .mem_write_data(mwd), .mem_write(mw),
    .mem_read(mr), .mem_read_data(mrd)
  );

  mem_bank_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(fa_gnt), .a_rvalid(fa_rvalid), .a_rdata(fa_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(fb_gnt), .b_rvalid(fb_rvalid), .b_rdata(fb_rdata),
    .mem_address(fmaddr), .mem_write_data(fmwd), .mem_write(fmw),
    .mem_read(fmr), .mem_read_data(fmrd)
  );

  // Bank models: contents start as addr+0x40, registered write and read.
  always @(posedge clk) begin
    if (!init0) begin
      for (int i = 0; i < 256; i++) bank0[i] <= 8'(i + 'h40);
      init0 <= 1'b1;
    end else begin
      if (mw) bank0[maddr] <= mwd;
      if (mr) mrd <= bank0[maddr];
    end
  end

  always @(posedge clk) begin
    if (!init1) begin
      for (int i = 0; i < 256; i++) bank1[i] <= 8'(i + 'h40);
      init1 <= 1'b1;
    end else begin
      if (fmw) bank1[fmaddr] <= fmwd;
      if (fmr) fmrd <= bank1[fmaddr];
    end
  end

  typedef struct {
    logic       a_req, a_we;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_we;
    logic [7:0] b_addr, b_wdata;
    logic       ag, bg, fag, fbg, mw, mr;
    logic [7:0] maddr, mwd;
    logic       av, bv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic aq, input logic awe, input logic [7:0] aad, input logic [7:0] awd,
                       input logic bq, input logic bwe, input logic [7:0] bad, input logic [7:0] bwd);
    a_req = aq; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = bq; b_we = bwe; b_addr = bad; b_wdata = bwd;
  endtask

  initial begin
    // inputs: aq awe aaddr awdata  bq bwe baddr bwdata
    // expect: ag bg fag fbg  mw mr maddr mwd  av bv rdata
    vecs[0]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h00,8'h00, 0,0,8'h00};
    vecs[1]  = '{1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0,1,0, 0,0,8'h00,8'h00, 0,0,8'h00};
    vecs[2]  = '{1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,1,0, 1,0,8'h10,8'hA5, 0,0,8'h00};
    vecs[3]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,1,8'h10,8'h00, 0,0,8'h00};
    vecs[4]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h10,8'h00, 1,0,8'hA5};
    vecs[5]  = '{1,0,8'h10,8'h00, 1,0,8'h11,8'h00, 0,1,1,0, 0,0,8'h10,8'h00, 0,0,8'h00};
    vecs[6]  = '{1,0,8'h10,8'h00, 1,0,8'h11,8'h00, 1,0,1,0, 0,1,8'h11,8'h00, 0,0,8'h00};
    vecs[7]  = '{1,0,8'h10,8'h00, 1,0,8'h11,8'h00, 0,1,1,0, 0,1,8'h10,8'h00, 0,1,8'h51};
    vecs[8]  = '{1,0,8'h10,8'h00, 1,0,8'h11,8'h00, 1,0,1,0, 0,1,8'h11,8'h00, 1,0,8'hA5};
    vecs[9]  = '{0,0,8'h00,8'h00, 1,0,8'h12,8'h00, 0,1,0,1, 0,1,8'h10,8'h00, 0,1,8'h51};
    vecs[10] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,1,8'h12,8'h00, 1,0,8'hA5};
    vecs[11] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h12,8'h00, 0,1,8'h52};
    vecs[12] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h12,8'h00, 0,0,8'h00};
    vecs[13] = '{0,0,8'h00,8'h00, 1,1,8'h20,8'h3C, 0,1,0,1, 0,0,8'h12,8'h00, 0,0,8'h00};
    vecs[14] = '{1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 1,0,1,0, 1,0,8'h20,8'h3C, 0,0,8'h00};
    vecs[15] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,1,8'h20,8'h00, 0,0,8'h00};
    vecs[16] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h20,8'h00, 1,0,8'h3C};
    vecs[17] = '{1,1,8'h30,8'h11, 1,1,8'h31,8'h22, 0,1,1,0, 0,0,8'h20,8'h00, 0,0,8'h00};
    vecs[18] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 1,0,8'h31,8'h22, 0,0,8'h00};
    vecs[19] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h31,8'h00, 0,0,8'h00};
    vecs[20] = '{1,0,8'h31,8'h00, 1,0,8'h30,8'h00, 1,0,1,0, 0,0,8'h31,8'h00, 0,0,8'h00};
    vecs[21] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,1,8'h31,8'h00, 0,0,8'h00};
    vecs[22] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h31,8'h00, 1,0,8'h22};

    // Reset: outputs cleared and grants suppressed even with requests up.
    rst_n = 1'b0;
    drive(1, 0, 8'h55, 8'h66, 1, 1, 8'h77, 8'h88);
    #2;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_fix_gnt", {fa_gnt, fb_gnt}, 0);
    chk("rst_mem_cmd", {mw, mr}, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mwd", mwd, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      drive(vecs[k].a_req, vecs[k].a_we, vecs[k].a_addr, vecs[k].a_wdata,
            vecs[k].b_req, vecs[k].b_we, vecs[k].b_addr, vecs[k].b_wdata);
      #2;
      chk($sformatf("row%0d_a_gnt", k), a_gnt, vecs[k].ag);
      chk($sformatf("row%0d_b_gnt", k), b_gnt, vecs[k].bg);
      chk($sformatf("row%0d_fix_a_gnt", k), fa_gnt, vecs[k].fag);
      chk($sformatf("row%0d_fix_b_gnt", k), fb_gnt, vecs[k].fbg);
      chk($sformatf("row%0d_mem_write", k), mw, vecs[k].mw);
      chk($sformatf("row%0d_mem_read", k), mr, vecs[k].mr);
      chk($sformatf("row%0d_mem_address", k), maddr, vecs[k].maddr);
      if (vecs[k].mw) chk($sformatf("row%0d_mem_write_data", k), mwd, vecs[k].mwd);
      chk($sformatf("row%0d_a_rvalid", k), a_rvalid, vecs[k].av);
      chk($sformatf("row%0d_b_rvalid", k), b_rvalid, vecs[k].bv);
      if (vecs[k].av) chk($sformatf("row%0d_a_rdata", k), a_rdata, vecs[k].rd);
      if (vecs[k].bv) chk($sformatf("row%0d_b_rdata", k), b_rdata, vecs[k].rd);
    end

    // a_rdata keeps the last returned value after the strobe ends.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hold_a_rvalid", a_rvalid, 0);
    chk("hold_a_rdata", a_rdata, 8'h22);
    chk("hold_b_rdata", b_rdata, 8'h52);

    // Reset during the cycle after a read accept: the read is dropped and the
    // pointer (currently at B) returns to A.
    @(negedge clk);
    drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 0);
    #2;
    chk("midrst_accept_a_gnt", a_gnt, 1);
    @(posedge clk);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_issued_read", mr, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read", mr, 0);
    chk("midrst_maddr", maddr, 0);
    chk("midrst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("midrst_rdata", {a_rdata, b_rdata}, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk($sformatf("postrst%0d_rvalid", i), {a_rvalid, b_rvalid}, 0);
    end
    @(negedge clk);
    drive(1, 0, 8'h33, 8'h00, 1, 0, 8'h34, 8'h00);
    #2;
    chk("postrst_ptr_a_gnt", a_gnt, 1);
    chk("postrst_ptr_b_gnt", b_gnt, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("postrst_mem_read", mr, 1);
    chk("postrst_maddr", maddr, 8'h33);
    @(negedge clk);
    #2;
    chk("postrst_a_rvalid", a_rvalid, 1);
    chk("postrst_a_rdata", a_rdata, 8'h73);
    chk("postrst_b_rvalid", b_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
